// File: rtl/sa_out_buf_writer.sv
`default_nettype none
// ============================================================================
// Module  : sa_out_buf_writer
// Brief   : Queues quantized output-channel vectors in a small skid FIFO and
//           writes them to the output buffer at tile_base + row.
// Revision: 1.0 - initial release
// ============================================================================
module sa_out_buf_writer #(
    parameter int LANES = 16,
    parameter int DW    = 8,
    parameter int ROWS  = 16,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           base_addr,
    input  logic                  q_valid,
    input  logic [5:0]            q_row_idx,
    input  logic [LANES*DW-1:0]   q_data,
    input  logic                  q_last,
    output logic                  ob_wr_en,
    output logic [15:0]           ob_addr,
    output logic [LANES*DW-1:0]   ob_wdata,
    input  logic                  ob_ready,
    output logic                  tile_done,
    output logic                  busy,
    output logic                  err_overflow,
    output logic                  err_rows
);

    localparam int          c_AW     = $clog2(DEPTH);
    localparam int          c_WW     = LANES * DW;
    localparam int          c_EW     = 16 + c_WW;
    localparam logic [15:0] c_ROWS16 = 16'(ROWS);
    localparam logic [8:0]  c_ROWS9  = 9'(ROWS);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [15:0]     tile_base_q, tile_base_d;
    logic [7:0]      row_cnt_q, row_cnt_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_rows_q, err_rows_d;
    logic [c_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_AW:0]   count_q, count_d;
    logic [c_EW-1:0] mem_q [DEPTH];

    logic            w_run, w_accept_v, w_accept_last;
    logic            w_empty, w_full, w_push, w_pop, w_drop;
    logic [15:0]     w_push_addr;
    logic [8:0]      w_rows_total;
    logic            w_row_oob;

    // A start pulse takes precedence over any vector arriving in the same cycle.
    assign w_run         = (state_q == c_RUN) && !start;
    assign w_accept_v    = w_run && q_valid;
    assign w_accept_last = w_run && q_last;

    assign w_empty  = (count_q == '0);
    assign w_full   = (count_q == c_FULL);
    assign w_pop    = !w_empty && ob_ready;
    assign w_push   = w_accept_v && (!w_full || w_pop);
    assign w_drop   = w_accept_v && w_full && !w_pop;

    assign w_push_addr  = tile_base_q + {10'b0, q_row_idx};
    assign w_rows_total = {1'b0, row_cnt_q} + {8'b0, w_accept_v};
    assign w_row_oob    = ({3'b0, q_row_idx} >= c_ROWS9);

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = c_RUN;
        end else begin
            case (state_q)
                c_RUN:   if (q_last)  state_d = c_DRAIN;
                c_DRAIN: if (w_empty) state_d = c_RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        tile_base_d = tile_base_q;
        row_cnt_d   = row_cnt_q;
        err_ovf_d   = err_ovf_q;
        err_rows_d  = err_rows_q;
        if (start) begin
            tile_base_d = base_addr;
            row_cnt_d   = '0;
            err_ovf_d   = 1'b0;
            err_rows_d  = 1'b0;
        end else begin
            if (w_drop) err_ovf_d = 1'b1;
            if (w_accept_v && w_row_oob) err_rows_d = 1'b1;
            if (w_accept_last) begin
                tile_base_d = tile_base_q + c_ROWS16;
                row_cnt_d   = '0;
                if (w_rows_total != c_ROWS9) err_rows_d = 1'b1;
            end else if (w_accept_v && (row_cnt_q != 8'hFF)) begin
                row_cnt_d = row_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= c_IDLE;
            tile_base_q <= '0;
            row_cnt_q   <= '0;
            err_ovf_q   <= 1'b0;
            err_rows_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            tile_base_q <= tile_base_d;
            row_cnt_q   <= row_cnt_d;
            err_ovf_q   <= err_ovf_d;
            err_rows_q  <= err_rows_d;
            count_q     <= count_d;
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= {w_push_addr, q_data};
    end

    assign ob_wr_en     = !w_empty;
    assign ob_addr      = mem_q[rd_ptr_q][c_EW-1:c_WW];
    assign ob_wdata     = mem_q[rd_ptr_q][c_WW-1:0];
    assign tile_done    = (state_q == c_DRAIN) && w_empty && !start;
    assign busy         = (state_q == c_DRAIN) || !w_empty;
    assign err_overflow = err_ovf_q;
    assign err_rows     = err_rows_q;

endmodule
`default_nettype wire
